// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top : ingredient-ID freshness checker
//
// Ranges {low, high, fresh} are written into a small input FIFO and drained,
// one per cycle, into a fixed-size range table.  Every cycle the registered
// check_addr is compared against all valid table entries.  An ID is fresh when it
// falls inside at least one fresh range and inside no spoiled range.
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-low reset
//   check_addr        ID to classify, registered every cycle
//   out_fresh         registered verdict, valid two edges after check_addr
//   wr_en             write strobe for one range
//   input_range_low   inclusive lower bound
//   input_range_high  inclusive upper bound
//   input_range_fresh 1 = fresh range, 0 = spoiled (exclusion) range
//   fifo_ready        registered; FIFO accepts a write this cycle
//   table_full        (only with TABLE_FULL_OUT_EN) all table slots valid
//
// Build option: define TABLE_FULL_OUT_EN to add the table_full output.
// ---------------------------------------------------------------------------
module top #(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_RANGES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] check_addr,
  output logic              out_fresh,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] input_range_low,
  input  logic [ADDR_W-1:0] input_range_high,
  input  logic              input_range_fresh,
  output logic              fifo_ready
`ifdef TABLE_FULL_OUT_EN
  ,
  output logic              table_full
`endif
);

  localparam int WORD_W = 2 * ADDR_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TIDX_W = $clog2(NUM_RANGES);
  localparam int TCNT_W = $clog2(NUM_RANGES + 1);
  localparam logic [FCNT_W-1:0] FIFO_DEPTH_C = FCNT_W'(FIFO_DEPTH);
  localparam logic [TCNT_W-1:0] NUM_RANGES_C = TCNT_W'(NUM_RANGES);

  // Input FIFO
  logic [WORD_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic              fifo_ready_q, fifo_ready_d;
  logic              push, pop;
  logic [WORD_W-1:0] head_word;
  logic [ADDR_W-1:0] head_low, head_high;
  logic              head_fresh;

  // Range table
  logic [ADDR_W-1:0]     tbl_low_q  [NUM_RANGES];
  logic [ADDR_W-1:0]     tbl_high_q [NUM_RANGES];
  logic [NUM_RANGES-1:0] tbl_fresh_q;
  logic [NUM_RANGES-1:0] tbl_valid_q;
  logic [TCNT_W-1:0]     tbl_cnt_q, tbl_cnt_d;
  logic [TIDX_W-1:0]     tbl_idx;
  logic                  tbl_full;

  // Lookup pipeline
  logic [ADDR_W-1:0] addr_q;
  logic              out_fresh_q;
  logic              any_fresh, any_spoiled;

  assign push      = wr_en && fifo_ready_q;
  assign tbl_full  = (tbl_cnt_q == NUM_RANGES_C);
  // The table only grows, so the fill count doubles as the next free slot.
  assign pop       = (fifo_cnt_q != '0) && !tbl_full;
  assign tbl_idx   = tbl_cnt_q[TIDX_W-1:0];
  assign head_word = fifo_mem_q[rd_ptr_q];
  assign {head_low, head_high, head_fresh} = head_word;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (pop && !push) fifo_cnt_d = fifo_cnt_q - 1'b1;
    fifo_ready_d = (fifo_cnt_d < FIFO_DEPTH_C);
    tbl_cnt_d    = pop ? tbl_cnt_q + 1'b1 : tbl_cnt_q;
  end

  // Spoiled matches veto fresh ones; an entry with low > high can never match.
  always_comb begin
    any_fresh   = 1'b0;
    any_spoiled = 1'b0;
    for (int i = 0; i < NUM_RANGES; i++) begin
      if (tbl_valid_q[i] && (tbl_low_q[i] <= addr_q) && (addr_q <= tbl_high_q[i])) begin
        if (tbl_fresh_q[i]) any_fresh = 1'b1;
        else                any_spoiled = 1'b1;
      end
    end
  end

  // NOTE: storage arrays are not reset; validity and pointers carry all state
  // that reset must clear, so the data words never need a reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {input_range_low, input_range_high, input_range_fresh};
    if (pop) begin
      tbl_low_q[tbl_idx]   <= head_low;
      tbl_high_q[tbl_idx]  <= head_high;
      tbl_fresh_q[tbl_idx] <= head_fresh;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      fifo_ready_q <= 1'b0;
      tbl_cnt_q    <= '0;
      tbl_valid_q  <= '0;
      addr_q       <= '0;
      out_fresh_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q             <= rd_ptr_q + 1'b1;
        tbl_valid_q[tbl_idx] <= 1'b1;
      end
      fifo_cnt_q   <= fifo_cnt_d;
      fifo_ready_q <= fifo_ready_d;
      tbl_cnt_q    <= tbl_cnt_d;
      addr_q       <= check_addr;
      out_fresh_q  <= any_fresh && !any_spoiled;
    end
  end

  assign out_fresh  = out_fresh_q;
  assign fifo_ready = fifo_ready_q;

`ifdef TABLE_FULL_OUT_EN
  logic table_full_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) table_full_q <= 1'b0;
    else      table_full_q <= (tbl_cnt_d == NUM_RANGES_C);
  end

  assign table_full = table_full_q;
`endif

endmodule

// File: tb/tb_top.sv
// ---------------------------------------------------------------------------
// tb_top : self-checking bench for the freshness checker.
// A queue-based reference model (FIFO queue + list of stored ranges) is
// advanced once per clock edge; DUT outputs are sampled 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_top;
  localparam int ADDR_W     = 17;
  localparam int FIFO_DEPTH = 16;
  localparam int NUM_RANGES = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] check_addr = '0;
  logic              out_fresh;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] input_range_low = '0;
  logic [ADDR_W-1:0] input_range_high = '0;
  logic              input_range_fresh = 1'b0;
  logic              fifo_ready;
`ifdef TABLE_FULL_OUT_EN
  logic              table_full;
`endif

  top #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .NUM_RANGES(NUM_RANGES)) dut (
    .clk               (clk),
    .rst               (rst),
    .check_addr        (check_addr),
    .out_fresh         (out_fresh),
    .wr_en             (wr_en),
    .input_range_low   (input_range_low),
    .input_range_high  (input_range_high),
    .input_range_fresh (input_range_fresh),
    .fifo_ready        (fifo_ready)
`ifdef TABLE_FULL_OUT_EN
    ,
    .table_full        (table_full)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned lo;
    int unsigned hi;
    bit          fr;
  } range_t;

  range_t      m_fifo[$];
  range_t      m_tbl[$];
  int unsigned m_addr;
  bit          m_out, m_ready, m_full;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Verdict straight from the rules: any fresh hit and no spoiled hit.
  function automatic bit verdict(input int unsigned a);
    bit f = 1'b0;
    bit s = 1'b0;
    foreach (m_tbl[i]) begin
      if (m_tbl[i].lo <= a && a <= m_tbl[i].hi) begin
        if (m_tbl[i].fr) f = 1'b1;
        else             s = 1'b1;
      end
    end
    return f && !s;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_tbl.delete();
    m_addr  = 0;
    m_out   = 1'b0;
    m_ready = 1'b0;
    m_full  = 1'b0;
  endtask

  // One clock edge: advance the model, then compare outputs.
  task automatic step();
    range_t r;
    bit     acc;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      acc    = wr_en && m_ready;
      m_out  = verdict(m_addr);
      m_addr = 32'(check_addr);
      if (m_fifo.size() > 0 && m_tbl.size() < NUM_RANGES) m_tbl.push_back(m_fifo.pop_front());
      if (acc) begin
        r.lo = 32'(input_range_low);
        r.hi = 32'(input_range_high);
        r.fr = input_range_fresh;
        m_fifo.push_back(r);
      end
      m_ready = (m_fifo.size() < FIFO_DEPTH);
      m_full  = (m_tbl.size() == NUM_RANGES);
    end
    #1;
    check("out_fresh", 32'(out_fresh), 32'(m_out));
    check("fifo_ready", 32'(fifo_ready), 32'(m_ready));
`ifdef TABLE_FULL_OUT_EN
    check("table_full", 32'(table_full), 32'(m_full));
`endif
  endtask

  task automatic wr(input int unsigned lo, input int unsigned hi, input bit fr);
    input_range_low   = ADDR_W'(lo);
    input_range_high  = ADDR_W'(hi);
    input_range_fresh = fr;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  // Present an ID and wait the two edges until its verdict is out.
  task automatic look_m(input int unsigned a);
    check_addr = ADDR_W'(a);
    step();
    step();
  endtask

  task automatic look(input int unsigned a, input bit exp);
    look_m(a);
    check($sformatf("look_%0d", a), 32'(out_fresh), 32'(exp));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) step();
    rst = 1'b1;
    step();
    check("ready_after_release", 32'(fifo_ready), 32'd1);
  endtask

  initial begin
    int unsigned lo, hi;
    model_reset();

    // Reset held for 10 cycles, fifo_ready rises one edge after release.
    do_reset(10);

    // Load and lookup
    wr(20, 24, 1'b1);
    wr(6, 8, 1'b1);
    repeat (4) step();
    look(6, 1'b1);  look(8, 1'b1);  look(20, 1'b1);
    look(22, 1'b1); look(24, 1'b1);
    look(5, 1'b0);  look(9, 1'b0);  look(19, 1'b0);
    look(25, 1'b0); look(0, 1'b0);  look(131071, 1'b0);

    // Exclusion overrides fresh
    wr(22, 22, 1'b0);
    repeat (3) step();
    look(22, 1'b0); look(21, 1'b1); look(23, 1'b1);

    // Empty range (low > high) on a clean table
    do_reset(2);
    wr(30, 10, 1'b1);
    repeat (3) step();
    look(10, 1'b0); look(20, 1'b0); look(30, 1'b0);

    // Backpressure: 32 entries fill the table, 16 fill the FIFO
    do_reset(2);
    for (int k = 100; k < 148; k++) wr(k, k, 1'b1);
    check("bp_ready_low", 32'(fifo_ready), 32'd0);
    wr(200, 200, 1'b1);
    repeat (3) step();
    look(200, 1'b0);
    for (int k = 100; k < 132; k++) look(k, 1'b1);
    for (int k = 132; k < 148; k++) look_m(k);

    // Reset mid-operation while lookups are streaming
    do_reset(2);
    wr(20, 24, 1'b1);
    repeat (3) step();
    for (int a = 20; a < 24; a++) begin
      check_addr = ADDR_W'(a);
      step();
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_fresh", 32'(out_fresh), 32'd0);
    check("async_rst_ready", 32'(fifo_ready), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    step();
    check_addr = ADDR_W'(20);
    repeat (4) begin
      step();
      check("post_rst_20", 32'(out_fresh), 32'd0);
    end
    wr(20, 24, 1'b1);
    repeat (3) step();
    look(20, 1'b1);

    // Randomised episodes against the model
    for (int ep = 0; ep < 6; ep++) begin
      do_reset(2);
      for (int c = 0; c < 300; c++) begin
        lo = $urandom_range(0, 63);
        hi = lo + $urandom_range(0, 12);
        if ($urandom_range(0, 9) == 0) hi = $urandom_range(0, 63);
        input_range_low   = ADDR_W'(lo);
        input_range_high  = ADDR_W'(hi);
        input_range_fresh = ($urandom_range(0, 3) != 0);
        wr_en             = ($urandom_range(0, 3) == 0);
        check_addr        = ADDR_W'($urandom_range(0, 80));
        step();
      end
      wr_en = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
